// File: rtl/wb_grf_pkg.sv
// Shared decode constants and types for the writeback stage / register file.
package wb_grf_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] FN_JALR    = 6'h09;
   localparam logic [4:0] REG_ZERO   = 5'd0;

   typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_type_e;
   typedef enum logic [1:0] {SEL_ALU, SEL_MEM, SEL_LINK} wb_sel_e;

   typedef struct packed {
      wb_sel_e  sel;
      ld_type_e ld;
   } wb_ctl_t;

   function automatic wb_ctl_t decode_wb(input logic [5:0] op, input logic [5:0] fn);
      wb_ctl_t c;
      c.sel = SEL_ALU;
      c.ld  = LD_W;
      case (op)
         OP_LW:      begin c.sel = SEL_MEM; c.ld = LD_W;  end
         OP_LB:      begin c.sel = SEL_MEM; c.ld = LD_B;  end
         OP_LBU:     begin c.sel = SEL_MEM; c.ld = LD_BU; end
         OP_LH:      begin c.sel = SEL_MEM; c.ld = LD_H;  end
         OP_LHU:     begin c.sel = SEL_MEM; c.ld = LD_HU; end
         OP_JAL:     c.sel = SEL_LINK;
         OP_SPECIAL: if (fn == FN_JALR) c.sel = SEL_LINK;
         default:    ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/wb_grf_if.sv
// W-stage bundle, D-stage read ports and forwarding export of the writeback/GRF block.
interface wb_grf_if;
   logic [31:0] instr_W;
   logic [31:0] PC_W;
   logic [31:0] PC8_W;
   logic [31:0] D_W;
   logic [31:0] C_W;
   logic [4:0]  A3_W;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   modport master (
      output instr_W, PC_W, PC8_W, D_W, C_W, A3_W, rs_addr, rt_addr,
      input  rs_data, rt_data, wb_we, wb_addr, wb_data
   );

   modport slave (
      input  instr_W, PC_W, PC8_W, D_W, C_W, A3_W, rs_addr, rt_addr,
      output rs_data, rt_data, wb_we, wb_addr, wb_data
   );
endinterface

// File: rtl/wb_grf_load_ext.sv
// Load data extraction: picks the byte/half addressed by addr out of the DM word and extends it.
module wb_grf_load_ext
   import wb_grf_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  addr,
   input  ld_type_e    ld_type,
   output logic [31:0] ext
);

   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic signed [31:0] byte_sx;
   logic signed [31:0] half_sx;

   always_comb begin
      case (addr)
         2'd0:    byte_sel = data[7:0];
         2'd1:    byte_sel = data[15:8];
         2'd2:    byte_sel = data[23:16];
         default: byte_sel = data[31:24];
      endcase
      // Misaligned halfword (addr[0]=1) still uses the half chosen by addr[1].
      half_sel = addr[1] ? data[31:16] : data[15:0];
      byte_sx  = 32'($signed(byte_sel));
      half_sx  = 32'($signed(half_sel));
      case (ld_type)
         LD_B:    ext = byte_sx;
         LD_BU:   ext = {24'h0, byte_sel};
         LD_H:    ext = half_sx;
         LD_HU:   ext = {16'h0, half_sel};
         default: ext = data;
      endcase
   end

endmodule

// File: rtl/wb_grf.sv
// Writeback select, 32x32 GRF with write-through read bypass, and retired-instruction counter.
// Optional write trace enabled by defining GRF_TRACE_EN.
module wb_grf
   import wb_grf_pkg::*;
#(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   wb_grf_if.slave             bus,
   output logic [RETIRE_W-1:0] retire_cnt
);

   logic [31:0] grf [32];
   wb_ctl_t     ctl;
   logic [31:0] load_data;
   logic [31:0] wb_data;
   logic        wb_we;

   assign ctl = decode_wb(bus.instr_W[31:26], bus.instr_W[5:0]);

   wb_grf_load_ext u_load_ext (
      .data    (bus.D_W),
      .addr    (bus.C_W[1:0]),
      .ld_type (ctl.ld),
      .ext     (load_data)
   );

   always_comb begin
      case (ctl.sel)
         SEL_MEM:  wb_data = load_data;
         SEL_LINK: wb_data = bus.PC8_W;
         default:  wb_data = bus.C_W;
      endcase
   end

   assign wb_we       = !reset && (bus.A3_W != REG_ZERO);
   assign bus.wb_we   = wb_we;
   assign bus.wb_addr = bus.A3_W;
   assign bus.wb_data = wb_data;

   // Reads see the current W write so D never needs a separate W->D forward.
   assign bus.rs_data = (bus.rs_addr == REG_ZERO)              ? 32'h0   :
                        (wb_we && bus.rs_addr == bus.A3_W)      ? wb_data :
                                                                  grf[bus.rs_addr];
   assign bus.rt_data = (bus.rt_addr == REG_ZERO)              ? 32'h0   :
                        (wb_we && bus.rt_addr == bus.A3_W)      ? wb_data :
                                                                  grf[bus.rt_addr];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) grf[i] <= 32'h0;
      end else if (wb_we) begin
         grf[bus.A3_W] <= wb_data;
      end
   end

   // Bubbles are all-zero instructions; stores and branches still retire.
   always_ff @(posedge clk) begin
      if (reset)
         retire_cnt <= '0;
      else if (bus.instr_W != 32'h0)
         retire_cnt <= retire_cnt + RETIRE_W'(1);
   end

`ifdef GRF_TRACE_EN
   always @(posedge clk) begin
      if (wb_we) $display("%d@%h: $%d <= %h", $time, bus.PC_W, bus.A3_W, wb_data);
   end
`else
   logic unused_pc;
   assign unused_pc = ^bus.PC_W;
`endif

endmodule
